// File: rtl/branch_unit.sv
// Branch resolution unit for a five-stage MIPS-style pipeline.
// Resolves conditional branches, jumps and jr in ID. It stalls while a branch
// or jr operand is still being produced, and redirects the fetch PC. There is
// no delay slot, so every redirect squashes the wrong-path instruction in IF/ID.
module branch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_in,
  input  logic             id_branch,
  input  logic             id_jump,
  input  logic             id_jr,
  input  logic             noteq,
  input  logic [31:0]      id_pc4,
  input  logic [15:0]      id_imm,
  input  logic [25:0]      id_jidx,
  input  logic [31:0]      id_rs_data,
  input  logic             dep_ex,
  input  logic             ex_is_load,
  input  logic             dep_mem_load,
  output logic [31:0]      pc,
  output logic             if_flush,
  output logic             branch_stall,
  output logic [CNT_W-1:0] taken_cnt
);

  // HOLD1 covers the second bubble needed when a load in EX feeds the branch.
  typedef enum logic {
    RUN   = 1'b0,
    HOLD1 = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               ctl;
  logic               hazard_stall;
  logic               resolve;
  logic               redirect;
  logic [31:0]        target;
  logic [31:0]        br_offset;

  // Only branches and jr read registers in ID, so only they can hit a data hazard.
  assign ctl = id_branch | id_jr;

  // Hazard FSM: decides the stall and the next state. A global stall freezes it.
  always_comb begin
    state_d      = state_q;
    hazard_stall = 1'b0;
    if (!stall_in) begin
      case (state_q)
        RUN: begin
          if (ctl && (dep_ex || dep_mem_load)) begin
            hazard_stall = 1'b1;
            if (dep_ex && ex_is_load) begin
              state_d = HOLD1;
            end
          end
        end
        HOLD1: begin
          hazard_stall = 1'b1;
          state_d      = RUN;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  assign resolve   = (state_q == RUN) && !stall_in && !hazard_stall;
  assign redirect  = resolve && (id_jr || id_jump || (id_branch && noteq));
  assign br_offset = {{14{id_imm[15]}}, id_imm, 2'b00};

  // Redirect target, with jr first, then jump, then branch.
  always_comb begin
    target = id_pc4 + br_offset;
    if (id_jr) begin
      target = id_rs_data;
    end else if (id_jump) begin
      target = {id_pc4[31:28], id_jidx, 2'b00};
    end
  end

  // Next fetch PC: hold on any stall, follow a redirect, otherwise step by one word.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (stall_in || hazard_stall) begin
      pc_d = pc_q;
    end else if (redirect) begin
      pc_d = target;
    end
  end

  // Taken-redirect counter that sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (redirect && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State, PC and counter registers. Reset also drops any pending HOLD1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // The combinational controls are gated by reset so they are quiet while it is held.
  assign pc           = pc_q;
  assign taken_cnt    = cnt_q;
  assign if_flush     = rst_n & redirect;
  assign branch_stall = rst_n & hazard_stall;

endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 The block SHALL expose these parameters, one per line (name, default, meaning):
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- CNT_W, 16, width of the taken-redirect counter.

REQ-002 The block SHALL expose these ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- stall_in, in, 1, global pipeline stall (load-use etc.); freezes PC and the FSM.
- id_branch, in, 1, instruction in ID is a conditional branch (beq/bne).
- id_jump, in, 1, instruction in ID is j/jal.
- id_jr, in, 1, instruction in ID is jr.
- noteq, in, 1, branch condition from the ID comparator; 1 = take branch.
- id_pc4, in, 32, PC+4 of the ID instruction.
- id_imm, in, 16, branch offset in words.
- id_jidx, in, 26, jump index.
- id_rs_data, in, 32, forwarded rs value (jr target).
- dep_ex, in, 1, EX instruction writes rs/rt of the ID instruction.
- ex_is_load, in, 1, EX instruction is a load.
- dep_mem_load, in, 1, MEM instruction is a load writing rs/rt of the ID instruction.
- pc, out, 32, fetch PC (registered).
- if_flush, out, 1, squash the IF/ID register at the coming edge.
- branch_stall, out, 1, hold IF/ID and PC; insert a bubble into EX.
- taken_cnt, out, CNT_W, count of taken redirects (registered).

Function
REQ-003 ctl SHALL be asserted when (id_branch | id_jr) is 1.
REQ-004 The FSM SHALL have exactly these states: RUN, HOLD1.
REQ-005 In RUN with ctl=1 and stall_in=0, the block SHALL assert branch_stall combinationally when dep_ex or dep_mem_load is 1.
REQ-006 In RUN with ctl=1, stall_in=0, dep_ex=1 and ex_is_load=1, the next state SHALL be HOLD1; every other RUN case SHALL remain in RUN.
REQ-007 In HOLD1, branch_stall SHALL be 1, the hazard inputs SHALL be ignored, and the next state SHALL be RUN.
- Resulting stall lengths: ALU dependency in EX = 1 cycle; load in EX = 2 cycles; load in MEM = 1 cycle.
REQ-008 A resolve cycle SHALL be one where state=RUN, stall_in=0 and branch_stall=0.
REQ-009 The redirect target SHALL be selected with this priority in a resolve cycle:
- jr: id_rs_data.
- jump: {id_pc4[31:28], id_jidx, 2'b00}.
- branch with noteq=1: id_pc4 + (sign-extended id_imm << 2), 32-bit wrap-around.
REQ-010 Next pc SHALL be, in priority order:
- pc held if stall_in=1 or branch_stall=1;
- the target if a redirect occurs;
- pc+4 otherwise, wrapping modulo 2^32.
REQ-011 There is no delay slot: if_flush SHALL equal 1 exactly in resolve cycles that redirect, and SHALL be combinational.
REQ-012 taken_cnt SHALL increment by 1 on each redirect edge and SHALL saturate at all-ones.
REQ-013 While stall_in=1, state, pc and taken_cnt SHALL hold, and if_flush and branch_stall SHALL be 0.
REQ-014 A branch with noteq=0 SHALL NOT flush and SHALL advance pc by 4.

Reset
REQ-015 On rst_n=0, independently of clk, the block SHALL immediately set:
- pc = RESET_PC;
- state = RUN;
- taken_cnt = 0;
- if_flush = 0 and branch_stall = 0 (both forced 0 while rst_n=0).
REQ-016 An assertion of rst_n mid-HOLD1 SHALL abandon the stall; the first edge after release SHALL fetch RESET_PC+4.

Verification
REQ-017 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Reset release, no ctl -> pc reads 0x3000, 0x3004, 0x3008 on successive edges; if_flush=0.
- Branch, noteq=1, id_pc4=0x3010, id_imm=16'hFFFC, no deps -> if_flush=1 for 1 cycle; next pc=0x3000; taken_cnt=1.
- Branch, dep_ex=1, ex_is_load=1, noteq=1 -> branch_stall=1 for exactly 2 cycles with pc held; then redirect with if_flush=1 for 1 cycle.
- jr with dep_mem_load=1, id_rs_data=0x0000_4000 -> 1 stall cycle, then pc=0x4000.
- stall_in=1 while id_jump=1 -> no flush and pc held; on stall_in=0, pc={id_pc4[31:28], id_jidx, 00}.
- taken_cnt forced to 0xFFFE, then 3 taken branches -> taken_cnt=0xFFFF and holds; rst_n pulse mid-HOLD1 -> pc=0x3000, branch_stall=0.
